calc_array: RTL and testbench
=============================

Name: calc_array

Overview:
- Parametrised successor of the fixed 40-lane perceptron engine.
- N lanes, built with a generate loop. Each lane is a fixed-point multiply-accumulate unit with a saturating accumulator and optional ReLU on output.
- Lane control is staggered by a configurable skew pipeline, so the array can run systolic or broadcast.
- Adds a global stall, load-and-MAC chaining, per-lane output valid and sticky saturation flags.

Parameters:
- N, 40: lane count (≥1).
- BA, 24: accumulator/activation/bias/output width, two's complement.
- BB, 16: weight width, two's complement.
- FRAC, 8: fractional bits shared by b and x (and therefore acc); product is arithmetically shifted right by FRAC.
- SKEW, 1: per-lane control delay in cycles (0 = broadcast, 1 = systolic stagger).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- a_bus  in  N*BA  per-lane bias/initial value; lane i = [(i+1)*BA-1 : i*BA].
- b_bus  in  N*BB  per-lane weight.
- x_bus  in  N*BA  per-lane activation input.
- load  in  1  acc <= a (lane-skewed).
- mac_en  in  1  acc += b*x (lane-skewed).
- fire  in  1  emit activated acc to out (lane-skewed).
- relu_en  in  1  ReLU select, travels with fire (lane-skewed).
- stall  in  1  global freeze, not skewed.
- out_bus  out  N*BA  registered lane results.
- out_valid  out  N  lane i result updated on previous edge.
- sat_flag  out  N  sticky saturation flag per lane.

Behaviour:
- Reset: acc, out_bus, out_valid, sat_flag and all skew-pipeline stages go to 0 on the rising edge with rst=1. Reset has priority over stall. Reset mid-sequence discards all pending skewed commands.
- Skew: control tuple {load, mac_en, fire, relu_en} reaches lane i delayed by i*SKEW cycles. Lane 0 has no delay.
  - Lane 0 acts on the edge that samples the command.
  - Lane i acts i*SKEW edges later.
  - Delay line per lane is i*SKEW registers (shared chain).
- Data alignment: lane i data buses are sampled on the edge where its delayed command acts. Upstream provides pre-skewed data.
- Stall=1: every register (acc, out, out_valid, sat_flag, skew chain) holds. Commands presented during stall are ignored, not queued.
- Product: p = (b*x) is a full BA+BB signed product. ps = p >>> FRAC (arithmetic, truncate toward −inf).
- MAC: sum = base + ps, where base = a if the lane's load=1, else acc. Sum is computed at BA+BB+1 bits and saturated to [−2^(BA−1), 2^(BA−1)−1].
- Lane command priority on an acting edge:
  - load=1, mac_en=0: acc <= a.
  - load=1, mac_en=1: acc <= sat(a + ps). This starts a new dot product with no bubble.
  - load=0, mac_en=1: acc <= sat(acc + ps).
  - Neither: acc holds.
- sat_flag[i]:
  - Set on any MAC whose sum was clamped.
  - Cleared by load without a simultaneous clamping MAC; a load+MAC that clamps leaves it 1.
  - Reset clears it.
- fire: out[i] <= relu_en ? max(acc,0) : acc.
  - Uses acc before this edge's update, so fire together with load/mac emits the previous result.
  - out_valid[i] <= 1 for exactly one unstalled cycle.
  - fire=0: out holds, out_valid[i] <= 0.
- Latency: command at edge t gives out_valid[i] high during cycle t+1+i*SKEW (no stalls). Each stall cycle adds one.
- Back-to-back fire every cycle is legal. Each fire produces a fresh out_valid pulse.

Test Plan:
- Reset (N=4, BA=24, BB=16, FRAC=8, SKEW=1): rst high 2 cycles with random inputs and commands → out_bus=0, out_valid=0, sat_flag=0. Commands issued 1 cycle before rst never appear afterwards.
- Dot product, lane 0: load a=0x000100, then mac b=0x0200, x=0x000300, then fire relu_en=1 → out[0]=0x000700, out_valid[0] pulse 1 cycle, sat_flag[0]=0.
- ReLU select: acc=0xFFFE00 (−2.0); fire relu_en=1 → out=0x000000. Fire relu_en=0 → out=0xFFFE00.
- Saturation: acc=0x7FFF00, mac b=0x7FFF, x=0x7FFFFF → out 0x7FFFFF, sat_flag=1.
  - acc=0x800100, mac b=0x7FFF, x=0x800000 → out 0x800000.
  - A following load clears the flag.
- Skew/chaining: fire pulse at edge t with SKEW=1 → out_valid[i] high at cycle t+1+i for i=0..3. With SKEW=0 all four are high at t+1. Load+mac+fire in one command emits the old acc, and the new acc = a+ps.
- Stall: 3-cycle stall inserted mid-sequence → identical out_bus values and sat_flag, out_valid delayed by 3. Commands during stall have no effect.

Source files
------------

// File: rtl/calc_array_if.sv
// calc_array_if: bundles the lane data buses, the command/stall controls and the per-lane
// results of calc_array.
//   master : drives a_bus/b_bus/x_bus, load/mac_en/fire/relu_en, stall; observes results
//   slave  : the array itself; receives commands and data, drives out_bus/out_valid/sat_flag
// Lane i of every bus occupies [(i+1)*W-1 : i*W] for that bus's element width W.
interface calc_array_if #(
    parameter int unsigned N  = 40,
    parameter int unsigned BA = 24,
    parameter int unsigned BB = 16
);
    logic [N*BA-1:0] a_bus;
    logic [N*BB-1:0] b_bus;
    logic [N*BA-1:0] x_bus;
    logic            load;
    logic            mac_en;
    logic            fire;
    logic            relu_en;
    logic            stall;
    logic [N*BA-1:0] out_bus;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    sat_flag;

    modport master (
        output a_bus, b_bus, x_bus, load, mac_en, fire, relu_en, stall,
        input  out_bus, out_valid, sat_flag
    );

    modport slave (
        input  a_bus, b_bus, x_bus, load, mac_en, fire, relu_en, stall,
        output out_bus, out_valid, sat_flag
    );
endinterface

// File: rtl/calc_array.sv
// calc_array: N-lane fixed-point multiply-accumulate array with saturating accumulators,
// optional ReLU on output, sticky per-lane saturation flags and a lane-staggered command skew.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (wins over stall)
//   bus  : calc_array_if slave port
//          a_bus/b_bus/x_bus  per-lane bias, weight, activation (pre-skewed by upstream)
//          load/mac_en/fire/relu_en  command tuple, reaches lane i after i*SKEW edges
//          stall              global freeze, never skewed
//          out_bus/out_valid/sat_flag  registered per-lane results
module calc_array #(
    parameter int unsigned N    = 40,
    parameter int unsigned BA   = 24,
    parameter int unsigned BB   = 16,
    parameter int unsigned FRAC = 8,
    parameter int unsigned SKEW = 1
) (
    input logic         clk,
    input logic         rst,
    calc_array_if.slave bus
);
    localparam int unsigned ChainLen   = (N - 1) * SKEW;
    localparam int unsigned ChainDepth = (ChainLen > 0) ? ChainLen : 1;
    localparam int unsigned PW         = BA + BB;
    localparam int unsigned SW         = BA + BB + 1;

    // Command bits: [3] load, [2] mac_en, [1] fire, [0] relu_en
    logic [3:0] cmd_in;
    logic [3:0] chain_q [ChainDepth];

    assign cmd_in = {bus.load, bus.mac_en, bus.fire, bus.relu_en};

    // One shared delay chain; lane i taps the output of stage i*SKEW-1.
    if (ChainLen > 0) begin : g_chain
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < ChainDepth; k++) chain_q[k] <= '0;
            end else if (!bus.stall) begin
                chain_q[0] <= cmd_in;
                for (int k = 1; k < ChainDepth; k++) chain_q[k] <= chain_q[k-1];
            end
        end
    end else begin : g_no_chain
        assign chain_q[0] = '0;
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [3:0]           cmd;
        logic [BA-1:0]        a;
        logic [BB-1:0]        b;
        logic [BA-1:0]        x;
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] prod_sh;
        logic [BA-1:0]        base;
        logic [SW-1:0]        sum;
        logic                 clamp;
        logic [BA-1:0]        sum_sat;
        logic [BA-1:0]        acc_q, acc_d;
        logic [BA-1:0]        out_q, out_d;
        logic                 valid_q, valid_d;
        logic                 sat_q, sat_d;

        if (i * SKEW == 0) begin : g_tap0
            assign cmd = cmd_in;
        end else begin : g_tapn
            assign cmd = chain_q[i*SKEW-1];
        end

        assign a = bus.a_bus[i*BA +: BA];
        assign b = bus.b_bus[i*BB +: BB];
        assign x = bus.x_bus[i*BA +: BA];

        // Full-width signed product, then arithmetic shift back to FRAC fractional bits
        assign prod    = $signed({{BA{b[BB-1]}}, b}) * $signed({{BB{x[BA-1]}}, x});
        assign prod_sh = prod >>> FRAC;

        assign base = cmd[3] ? a : acc_q;
        assign sum  = {{(BB+1){base[BA-1]}}, base} + {prod_sh[PW-1], prod_sh};

        // In range iff every bit from the result sign upward agrees
        assign clamp   = !((&sum[SW-1:BA-1]) || !(|sum[SW-1:BA-1]));
        assign sum_sat = !clamp     ? sum[BA-1:0] :
                         sum[SW-1]  ? {1'b1, {(BA-1){1'b0}}} :
                                      {1'b0, {(BA-1){1'b1}}};

        always_comb begin
            acc_d   = acc_q;
            sat_d   = sat_q;
            out_d   = out_q;
            valid_d = 1'b0;
            if (cmd[2]) begin
                acc_d = sum_sat;
                if (clamp) begin
                    sat_d = 1'b1;
                end else if (cmd[3]) begin
                    sat_d = 1'b0;
                end
            end else if (cmd[3]) begin
                acc_d = a;
                sat_d = 1'b0;
            end
            // fire reports the accumulator as it stood before this edge
            if (cmd[1]) begin
                out_d   = (cmd[0] && acc_q[BA-1]) ? '0 : acc_q;
                valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q   <= '0;
                out_q   <= '0;
                valid_q <= 1'b0;
                sat_q   <= 1'b0;
            end else if (!bus.stall) begin
                acc_q   <= acc_d;
                out_q   <= out_d;
                valid_q <= valid_d;
                sat_q   <= sat_d;
            end
        end

        assign bus.out_bus[i*BA +: BA] = out_q;
        assign bus.out_valid[i]        = valid_q;
        assign bus.sat_flag[i]         = sat_q;
    end
endmodule

// File: tb/tb_calc_array.sv
// tb_calc_array: self-checking bench for calc_array (N=4, BA=24, BB=16, FRAC=8, SKEW=1) with a
// second SKEW=0 instance sharing the same stimulus. A cycle model pushes expected results to a
// scoreboard when a lane fires; results are popped when the DUT raises out_valid.
module tb_calc_array;
    localparam int unsigned N    = 4;
    localparam int unsigned BA   = 24;
    localparam int unsigned BB   = 16;
    localparam int unsigned FRAC = 8;
    localparam int unsigned SKEW = 1;
    localparam longint      MaxV = (longint'(1) <<< (BA - 1)) - 1;
    localparam longint      MinV = -(longint'(1) <<< (BA - 1));
    localparam logic [63:0] Mask = (64'd1 << BA) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    calc_array_if #(.N(N), .BA(BA), .BB(BB)) bif ();
    calc_array_if #(.N(N), .BA(BA), .BB(BB)) bif0 ();

    assign bif0.a_bus   = bif.a_bus;
    assign bif0.b_bus   = bif.b_bus;
    assign bif0.x_bus   = bif.x_bus;
    assign bif0.load    = bif.load;
    assign bif0.mac_en  = bif.mac_en;
    assign bif0.fire    = bif.fire;
    assign bif0.relu_en = bif.relu_en;
    assign bif0.stall   = bif.stall;

    calc_array #(.N(N), .BA(BA), .BB(BB), .FRAC(FRAC), .SKEW(SKEW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    calc_array #(.N(N), .BA(BA), .BB(BB), .FRAC(FRAC), .SKEW(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bif0)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int     lane;
        longint val;
    } exp_t;

    typedef struct {
        logic [BA-1:0] a;
        logic [BB-1:0] b;
        logic [BA-1:0] x;
        bit            relu;
        logic [BA-1:0] exp_out;
        bit            exp_sat;
    } vec_t;

    exp_t         sb[$];
    logic [3:0]   hist[$];
    longint       m_acc[N];
    longint       m_out[N];
    logic [N-1:0] m_valid;
    logic [N-1:0] m_sat;
    bit           e_rst;
    bit           e_stall;
    vec_t         vt[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic longint sx_ba(input logic [N*BA-1:0] v, input int i);
        logic [BA-1:0] s;
        s = v[i*BA +: BA];
        return longint'($signed(s));
    endfunction

    function automatic longint sx_bb(input logic [N*BB-1:0] v, input int i);
        logic [BB-1:0] s;
        s = v[i*BB +: BB];
        return longint'($signed(s));
    endfunction

    function automatic logic [63:0] lane_out(input int i);
        return 64'(bif.out_bus[i*BA +: BA]);
    endfunction

    // Behavioural model of one clock edge, evaluated with the inputs the DUT sampled.
    task automatic model_edge();
        logic [3:0] c;
        longint     a, ps, base, sum;
        exp_t       e;
        e_rst   = rst;
        e_stall = bif.stall;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_acc[i] = 0;
                m_out[i] = 0;
            end
            m_valid = '0;
            m_sat   = '0;
            hist.delete();
            return;
        end
        if (bif.stall) return;
        hist.push_front({bif.load, bif.mac_en, bif.fire, bif.relu_en});
        if (hist.size() > int'((N - 1) * SKEW + 1)) void'(hist.pop_back());
        for (int i = 0; i < N; i++) begin
            c    = (i * SKEW < hist.size()) ? hist[i*SKEW] : 4'b0000;
            a    = sx_ba(bif.a_bus, i);
            ps   = (sx_bb(bif.b_bus, i) * sx_ba(bif.x_bus, i)) >>> FRAC;
            if (c[1]) begin
                m_out[i]   = (c[0] && m_acc[i] < 0) ? 0 : m_acc[i];
                m_valid[i] = 1'b1;
                e.lane     = i;
                e.val      = m_out[i];
                sb.push_back(e);
            end else begin
                m_valid[i] = 1'b0;
            end
            base = c[3] ? a : m_acc[i];
            if (c[2]) begin
                sum = base + ps;
                if (sum > MaxV) begin
                    m_acc[i] = MaxV;
                    m_sat[i] = 1'b1;
                end else if (sum < MinV) begin
                    m_acc[i] = MinV;
                    m_sat[i] = 1'b1;
                end else begin
                    m_acc[i] = sum;
                    if (c[3]) m_sat[i] = 1'b0;
                end
            end else if (c[3]) begin
                m_acc[i] = a;
                m_sat[i] = 1'b0;
            end
        end
    endtask

    task automatic cycle_check();
        exp_t e;
        if (!e_rst && !e_stall) begin
            for (int i = 0; i < N; i++) begin
                if (bif.out_valid[i]) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL sb_pop lane %0d: got a result, expected none pending", i);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_lane", 64'(i), 64'(e.lane));
                        chk($sformatf("sb_val_lane%0d", i), lane_out(i), 64'(e.val) & Mask);
                    end
                end
            end
        end
        chk("valid_vec", 64'(bif.out_valid), 64'(m_valid));
        chk("sat_vec", 64'(bif.sat_flag), 64'(m_sat));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("out_lane%0d", i), lane_out(i), 64'(m_out[i]) & Mask);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cycle_check();
    endtask

    task automatic cmd(input bit ld, input bit mc, input bit fr, input bit rl);
        bif.load    = ld;
        bif.mac_en  = mc;
        bif.fire    = fr;
        bif.relu_en = rl;
    endtask

    task automatic set_all(input logic [BA-1:0] a, input logic [BB-1:0] b,
                           input logic [BA-1:0] x);
        for (int i = 0; i < N; i++) begin
            bif.a_bus[i*BA +: BA] = a;
            bif.b_bus[i*BB +: BB] = b;
            bif.x_bus[i*BA +: BA] = x;
        end
    endtask

    // Moderate random data: 16-bit signed values so accumulations only sometimes saturate
    task automatic rand_lanes();
        logic [15:0] ra, rb, rx;
        for (int i = 0; i < N; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rx = 16'($urandom);
            bif.a_bus[i*BA +: BA] = {{(BA-16){ra[15]}}, ra};
            bif.b_bus[i*BB +: BB] = rb;
            bif.x_bus[i*BA +: BA] = {{(BA-16){rx[15]}}, rx};
        end
    endtask

    task automatic idle(input int n);
        cmd(0, 0, 0, 0);
        bif.stall = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        vt[0] = '{24'h000100, 16'h0200, 24'h000300, 1'b1, 24'h000700, 1'b0};
        vt[1] = '{24'hFFFE00, 16'h0000, 24'h000000, 1'b1, 24'h000000, 1'b0};
        vt[2] = '{24'hFFFE00, 16'h0000, 24'h000000, 1'b0, 24'hFFFE00, 1'b0};
        vt[3] = '{24'h7FFF00, 16'h7FFF, 24'h7FFFFF, 1'b0, 24'h7FFFFF, 1'b1};
        vt[4] = '{24'h800100, 16'h7FFF, 24'h800000, 1'b0, 24'h800000, 1'b1};
        vt[5] = '{24'h000000, 16'hFFFF, 24'h000001, 1'b0, 24'hFFFFFF, 1'b0};
        vt[6] = '{24'h000000, 16'h0100, 24'h7FFFFF, 1'b0, 24'h7FFFFF, 1'b0};
        vt[7] = '{24'hFFFFFF, 16'h0100, 24'h800000, 1'b0, 24'h800000, 1'b1};

        rst = 1'b1;
        bif.stall = 1'b0;
        cmd(0, 0, 0, 0);
        set_all('0, '0, '0);

        // Reset with random data and commands
        for (int k = 0; k < 2; k++) begin
            rand_lanes();
            cmd(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            bif.stall = 1'($urandom);
            step();
        end
        chk("rst_out_zero", 64'(|bif.out_bus), 64'd0);
        chk("rst_valid_zero", 64'(bif.out_valid), 64'd0);
        chk("rst_sat_zero", 64'(bif.sat_flag), 64'd0);

        // A command one cycle before reset must leave nothing pending afterwards
        rst = 1'b0;
        bif.stall = 1'b0;
        rand_lanes();
        cmd(1, 1, 1, 0);
        step();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rand_lanes();
            cmd(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        rst = 1'b0;
        cmd(0, 0, 0, 0);
        for (int k = 0; k < int'(N) + 2; k++) begin
            step();
            chk("rst_no_pending", 64'(bif.out_valid), 64'd0);
        end

        // Table: load a, mac b*x, fire on lane 0
        foreach (vt[v]) begin
            set_all(vt[v].a, vt[v].b, vt[v].x);
            cmd(1, 0, 0, 0);
            step();
            chk($sformatf("vec%0d_load_clears_sat", v), 64'(bif.sat_flag[0]), 64'd0);
            cmd(0, 1, 0, 0);
            step();
            cmd(0, 0, 1, vt[v].relu);
            step();
            chk($sformatf("vec%0d_out", v), lane_out(0), 64'(vt[v].exp_out));
            chk($sformatf("vec%0d_valid", v), 64'(bif.out_valid[0]), 64'd1);
            chk($sformatf("vec%0d_sat", v), 64'(bif.sat_flag[0]), 64'(vt[v].exp_sat));
            cmd(0, 0, 0, 0);
            step();
            chk($sformatf("vec%0d_valid_pulse", v), 64'(bif.out_valid[0]), 64'd0);
        end
        idle(N + 1);

        // Chained load+mac+fire emits the old accumulator, then holds a+ps
        set_all(24'h000500, 16'h0000, 24'h000000);
        cmd(1, 0, 0, 0);
        step();
        set_all(24'h000100, 16'h0100, 24'h000200);
        cmd(1, 1, 1, 0);
        step();
        chk("chain_old_acc", lane_out(0), 64'h000500);
        cmd(0, 0, 1, 0);
        step();
        chk("chain_new_acc", lane_out(0), 64'h000300);
        idle(N + 1);

        // Skew: lone fire walks across the lanes; SKEW=0 instance fires all at once
        cmd(0, 0, 1, 0);
        step();
        chk("skew1_t1", 64'(bif.out_valid), 64'b0001);
        chk("skew0_t1", 64'(bif0.out_valid), 64'b1111);
        cmd(0, 0, 0, 0);
        step();
        chk("skew1_t2", 64'(bif.out_valid), 64'b0010);
        chk("skew0_t2", 64'(bif0.out_valid), 64'b0000);
        step();
        chk("skew1_t3", 64'(bif.out_valid), 64'b0100);
        step();
        chk("skew1_t4", 64'(bif.out_valid), 64'b1000);
        step();
        chk("skew1_t5", 64'(bif.out_valid), 64'b0000);
        idle(2);

        // Stall mid-sequence: commands during stall ignored, results delayed by 3
        set_all(24'h000A00, 16'h0100, 24'h000100);
        cmd(1, 0, 0, 0);
        step();
        cmd(0, 1, 0, 0);
        step();
        cmd(0, 0, 1, 0);
        step();
        chk("stall_pre_valid", 64'(bif.out_valid), 64'b0001);
        chk("stall_pre_out", lane_out(0), 64'h000B00);
        bif.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_lanes();
            cmd(1, 1, 1, 1'($urandom));
            step();
            chk("stall_hold_valid", 64'(bif.out_valid), 64'b0001);
            chk("stall_hold_sat", 64'(bif.sat_flag), 64'd0);
        end
        bif.stall = 1'b0;
        set_all(24'h000A00, 16'h0100, 24'h000100);
        cmd(0, 0, 0, 0);
        for (int k = 1; k < int'(N); k++) begin
            step();
            chk($sformatf("stall_valid_lane%0d", k), 64'(bif.out_valid), 64'(1 << k));
            chk($sformatf("stall_out_lane%0d", k), lane_out(k), 64'h000B00);
        end
        step();
        chk("stall_done", 64'(bif.out_valid), 64'd0);

        // Random traffic including back-to-back fires and random stalls
        for (int c = 0; c < 150; c++) begin
            rand_lanes();
            bif.stall = ($urandom_range(0, 4) == 0);
            cmd($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        idle(N + 2);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
